// File: rtl/stopwatch_core.sv
// stopwatch_core: MM:SS BCD timekeeping core.
// Counts 1 Hz strobes while running, supports pause/resume, clear, and
// per-field adjust with a blink mask for the display multiplexer.
//
//   state     | meaning
//   ----------+----------------------------------------------------------
//   ST_RUN    | ONE_TICK advances MM:SS with carries, RUNNING = 1
//   ST_PAUSED | count frozen, PAUSE_PULSE resumes
//   ST_ADJUST | ADJ_TICK bumps the SEL field, BLINK_TICK toggles blink phase
module stopwatch_core #(
  parameter int MAX_MINUTES  = 59,
  parameter bit START_PAUSED = 1'b0
) (
  input  logic       M_CLK,
  input  logic       RST_N,
  input  logic       ONE_TICK,
  input  logic       BLINK_TICK,
  input  logic       ADJ_TICK,
  input  logic       PAUSE_PULSE,
  input  logic       CLEAR_PULSE,
  input  logic       ADJ,
  input  logic       SEL,
  output logic [3:0] MIN_TENS,
  output logic [3:0] MIN_ONES,
  output logic [3:0] SEC_TENS,
  output logic [3:0] SEC_ONES,
  output logic       RUNNING,
  output logic       BLANK_MIN,
  output logic       BLANK_SEC
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_PAUSED = 2'd1,
    ST_ADJUST = 2'd2
  } state_e;

  localparam state_e     RESET_STATE = START_PAUSED ? ST_PAUSED : ST_RUN;
  localparam logic [3:0] MAX_MT      = 4'(MAX_MINUTES / 10);
  localparam logic [3:0] MAX_MO      = 4'(MAX_MINUTES % 10);

  state_e     state_q, state_d;
  state_e     saved_q, saved_d;
  logic       phase_q, phase_d;

  logic [3:0] min_tens_q, min_tens_d;
  logic [3:0] min_ones_q, min_ones_d;
  logic [3:0] sec_tens_q, sec_tens_d;
  logic [3:0] sec_ones_q, sec_ones_d;

  logic       running_q, running_d;
  logic       blank_min_q, blank_min_d;
  logic       blank_sec_q, blank_sec_d;

  // Field increment helpers: wrapped +1 for each field, shared by count and adjust
  logic [3:0] sec_inc_tens, sec_inc_ones;
  logic [3:0] min_inc_tens, min_inc_ones;
  logic       sec_wraps;

  // State, saved state and blink phase registers
  always_ff @(posedge M_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= RESET_STATE;
      saved_q <= RESET_STATE;
      phase_q <= 1'b0;
    end else begin
      state_q <= state_d;
      saved_q <= saved_d;
      phase_q <= phase_d;
    end
  end

  // Next-state: ADJ dominates, PAUSE_PULSE only toggles RUN/PAUSED outside adjust
  always_comb begin
    state_d = state_q;
    saved_d = saved_q;
    unique case (state_q)
      ST_RUN, ST_PAUSED: begin
        if (ADJ) begin
          state_d = ST_ADJUST;
          saved_d = state_q;
        end else if (PAUSE_PULSE) begin
          state_d = (state_q == ST_RUN) ? ST_PAUSED : ST_RUN;
        end
      end
      ST_ADJUST: begin
        if (!ADJ) state_d = saved_q;
      end
      default: state_d = RESET_STATE;
    endcase
  end

  // Blink phase: cleared on any entry to or exit from adjust, toggled by BLINK_TICK inside it
  always_comb begin
    phase_d = phase_q;
    if ((state_q == ST_ADJUST) != (state_d == ST_ADJUST)) begin
      phase_d = 1'b0;
    end else if (state_q == ST_ADJUST && BLINK_TICK) begin
      phase_d = ~phase_q;
    end
  end

  // Seconds +1 with 59 -> 00 wrap; sec_wraps flags the carry into minutes
  always_comb begin
    sec_inc_tens = sec_tens_q;
    sec_inc_ones = sec_ones_q + 4'd1;
    sec_wraps    = 1'b0;
    if (sec_ones_q >= 4'd9) begin
      sec_inc_ones = 4'd0;
      if (sec_tens_q >= 4'd5) begin
        sec_inc_tens = 4'd0;
        sec_wraps    = 1'b1;
      end else begin
        sec_inc_tens = sec_tens_q + 4'd1;
      end
    end
  end

  // Minutes +1 with MAX_MINUTES -> 00 wrap
  always_comb begin
    min_inc_tens = min_tens_q;
    min_inc_ones = min_ones_q + 4'd1;
    if (min_tens_q == MAX_MT && min_ones_q == MAX_MO) begin
      min_inc_tens = 4'd0;
      min_inc_ones = 4'd0;
    end else if (min_ones_q >= 4'd9) begin
      min_inc_tens = min_tens_q + 4'd1;
      min_inc_ones = 4'd0;
    end
  end

  // Digit update: clear wins, then counting (RUN) or field adjust (ADJUST), judged on state_q
  always_comb begin
    min_tens_d = min_tens_q;
    min_ones_d = min_ones_q;
    sec_tens_d = sec_tens_q;
    sec_ones_d = sec_ones_q;
    if (CLEAR_PULSE) begin
      min_tens_d = 4'd0;
      min_ones_d = 4'd0;
      sec_tens_d = 4'd0;
      sec_ones_d = 4'd0;
    end else if (state_q == ST_RUN && ONE_TICK) begin
      sec_tens_d = sec_inc_tens;
      sec_ones_d = sec_inc_ones;
      if (sec_wraps) begin
        min_tens_d = min_inc_tens;
        min_ones_d = min_inc_ones;
      end
    end else if (state_q == ST_ADJUST && ADJ_TICK) begin
      if (SEL) begin
        sec_tens_d = sec_inc_tens;
        sec_ones_d = sec_inc_ones;
      end else begin
        min_tens_d = min_inc_tens;
        min_ones_d = min_inc_ones;
      end
    end
  end

  // Output decode from the next state so every output is a flop
  always_comb begin
    running_d   = (state_d == ST_RUN);
    blank_sec_d = phase_d & SEL;
    blank_min_d = phase_d & ~SEL;
  end

  // Digit registers
  always_ff @(posedge M_CLK or negedge RST_N) begin
    if (!RST_N) begin
      min_tens_q <= 4'd0;
      min_ones_q <= 4'd0;
      sec_tens_q <= 4'd0;
      sec_ones_q <= 4'd0;
    end else begin
      min_tens_q <= min_tens_d;
      min_ones_q <= min_ones_d;
      sec_tens_q <= sec_tens_d;
      sec_ones_q <= sec_ones_d;
    end
  end

  // Status output registers
  always_ff @(posedge M_CLK or negedge RST_N) begin
    if (!RST_N) begin
      running_q   <= (RESET_STATE == ST_RUN);
      blank_min_q <= 1'b0;
      blank_sec_q <= 1'b0;
    end else begin
      running_q   <= running_d;
      blank_min_q <= blank_min_d;
      blank_sec_q <= blank_sec_d;
    end
  end

  assign MIN_TENS  = min_tens_q;
  assign MIN_ONES  = min_ones_q;
  assign SEC_TENS  = sec_tens_q;
  assign SEC_ONES  = sec_ones_q;
  assign RUNNING   = running_q;
  assign BLANK_MIN = blank_min_q;
  assign BLANK_SEC = blank_sec_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// tb_stopwatch_core: directed vectors with hand-computed MM:SS expectations.
module tb_stopwatch_core;

  logic       M_CLK = 1'b0;
  logic       RST_N;
  logic       ONE_TICK, BLINK_TICK, ADJ_TICK, PAUSE_PULSE, CLEAR_PULSE;
  logic       ADJ, SEL;
  logic [3:0] MIN_TENS, MIN_ONES, SEC_TENS, SEC_ONES;
  logic       RUNNING, BLANK_MIN, BLANK_SEC;
  logic [15:0] mmss;

  int n_checks = 0;
  int n_fail   = 0;

  stopwatch_core #(.MAX_MINUTES(59), .START_PAUSED(1'b0)) dut (
    .M_CLK       (M_CLK),
    .RST_N       (RST_N),
    .ONE_TICK    (ONE_TICK),
    .BLINK_TICK  (BLINK_TICK),
    .ADJ_TICK    (ADJ_TICK),
    .PAUSE_PULSE (PAUSE_PULSE),
    .CLEAR_PULSE (CLEAR_PULSE),
    .ADJ         (ADJ),
    .SEL         (SEL),
    .MIN_TENS    (MIN_TENS),
    .MIN_ONES    (MIN_ONES),
    .SEC_TENS    (SEC_TENS),
    .SEC_ONES    (SEC_ONES),
    .RUNNING     (RUNNING),
    .BLANK_MIN   (BLANK_MIN),
    .BLANK_SEC   (BLANK_SEC)
  );

  assign mmss = {MIN_TENS, MIN_ONES, SEC_TENS, SEC_ONES};

  always #5 M_CLK = ~M_CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock with the given strobes; outputs are stable #1 after the edge
  task automatic cyc(input logic one, input logic pause, input logic clr,
                     input logic adjt, input logic blink);
    ONE_TICK    = one;
    PAUSE_PULSE = pause;
    CLEAR_PULSE = clr;
    ADJ_TICK    = adjt;
    BLINK_TICK  = blink;
    @(posedge M_CLK);
    #1;
    ONE_TICK    = 1'b0;
    PAUSE_PULSE = 1'b0;
    CLEAR_PULSE = 1'b0;
    ADJ_TICK    = 1'b0;
    BLINK_TICK  = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic adj_ticks(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST_N = 1'b0;
    ONE_TICK = 1'b0; BLINK_TICK = 1'b0; ADJ_TICK = 1'b0;
    PAUSE_PULSE = 1'b0; CLEAR_PULSE = 1'b0;
    ADJ = 1'b0; SEL = 1'b0;
    #12;
    check("rst_digits", 32'(mmss), 32'h0000);
    check("rst_running", 32'(RUNNING), 32'd1);
    check("rst_blank_min", 32'(BLANK_MIN), 32'd0);
    check("rst_blank_sec", 32'(BLANK_SEC), 32'd0);
    @(negedge M_CLK);
    RST_N = 1'b1;

    // Plain counting with carries
    ticks(61);
    check("cnt61", 32'(mmss), 32'h0101);
    check("cnt61_running", 32'(RUNNING), 32'd1);
    check("cnt61_blanks", 32'({BLANK_MIN, BLANK_SEC}), 32'd0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("clear_run", 32'(mmss), 32'h0000);
    ticks(599);
    check("cnt0959", 32'(mmss), 32'h0959);
    ticks(1);
    check("cnt1000", 32'(mmss), 32'h1000);

    // Preload 59:59 via adjust, then wrap to 00:00
    ADJ = 1'b1; SEL = 1'b0;
    idle();
    check("adj_enter_running", 32'(RUNNING), 32'd0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("clear_in_adj", 32'(mmss), 32'h0000);
    check("clear_in_adj_state", 32'(RUNNING), 32'd0);
    adj_ticks(59);
    SEL = 1'b1;
    adj_ticks(59);
    check("preload5959", 32'(mmss), 32'h5959);
    ADJ = 1'b0;
    idle();
    check("adj_exit_running", 32'(RUNNING), 32'd1);
    ticks(1);
    check("wrap5959", 32'(mmss), 32'h0000);

    // Pause with simultaneous tick
    ticks(5);
    check("cnt0005", 32'(mmss), 32'h0005);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("pause_tick_digits", 32'(mmss), 32'h0006);
    check("pause_tick_running", 32'(RUNNING), 32'd0);
    ticks(3);
    check("paused_ignore", 32'(mmss), 32'h0006);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("resume_tick_digits", 32'(mmss), 32'h0006);
    check("resume_tick_running", 32'(RUNNING), 32'd1);

    // Seconds adjust, blink on seconds
    ticks(52);
    check("cnt0058", 32'(mmss), 32'h0058);
    ADJ = 1'b1; SEL = 1'b1;
    idle();
    adj_ticks(3);
    check("adj_sec_wrap", 32'(mmss), 32'h0001);
    ticks(4);
    check("adj_ignore_tick", 32'(mmss), 32'h0001);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("blink_sec", 32'(BLANK_SEC), 32'd1);
    check("blink_sec_min", 32'(BLANK_MIN), 32'd0);
    ADJ = 1'b0;
    idle();
    check("exit_blanks", 32'({BLANK_MIN, BLANK_SEC}), 32'd0);
    check("exit_running", 32'(RUNNING), 32'd1);

    // ADJ rising with ONE_TICK and ADJ_TICK: count applies, adjust ignored
    ADJ = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("adj_rise_tick", 32'(mmss), 32'h0002);
    check("adj_rise_running", 32'(RUNNING), 32'd0);
    SEL = 1'b1;
    adj_ticks(5);
    SEL = 1'b0;
    adj_ticks(58);
    check("adj_min58", 32'(mmss), 32'h5807);
    adj_ticks(2);
    check("adj_min_wrap", 32'(mmss), 32'h0007);
    SEL = 1'b1;
    adj_ticks(1);
    check("sel_redirect", 32'(mmss), 32'h0008);
    SEL = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("blink_min", 32'({BLANK_MIN, BLANK_SEC}), 32'b10);
    SEL = 1'b1;
    idle();
    check("blink_mask_sel", 32'({BLANK_MIN, BLANK_SEC}), 32'b01);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("pause_in_adj", 32'(RUNNING), 32'd0);
    ADJ = 1'b0;
    idle();
    check("exit2_running", 32'(RUNNING), 32'd1);
    check("exit2_blanks", 32'({BLANK_MIN, BLANK_SEC}), 32'd0);

    // 12:34 then clear with simultaneous tick
    ADJ = 1'b1;
    idle();
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    SEL = 1'b0;
    adj_ticks(12);
    SEL = 1'b1;
    adj_ticks(34);
    ADJ = 1'b0;
    idle();
    check("preload1234", 32'(mmss), 32'h1234);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("clear_tick", 32'(mmss), 32'h0000);
    check("clear_tick_running", 32'(RUNNING), 32'd1);

    // Asynchronous reset between edges with a pending strobe
    ticks(3);
    check("cnt0003", 32'(mmss), 32'h0003);
    @(posedge M_CLK);
    #3;
    ONE_TICK = 1'b1;
    RST_N = 1'b0;
    #1;
    check("async_rst_digits", 32'(mmss), 32'h0000);
    @(posedge M_CLK);
    #1;
    check("rst_hold_digits", 32'(mmss), 32'h0000);
    check("rst_hold_running", 32'(RUNNING), 32'd1);
    ONE_TICK = 1'b0;
    @(negedge M_CLK);
    RST_N = 1'b1;
    ticks(2);
    check("post_rst_cnt", 32'(mmss), 32'h0002);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
